uart_rx_sampler: RTL and testbench

Receive-side UART stage sitting directly downstream of the baud generator. Consumes the generator's 16x-oversampling tick strobe, synchronizes the serial `rx` line, and detects start bits. Samples each bit at its centre and delivers completed bytes through a one-entry valid/ready holding buffer, with framing-error and overrun reporting.

---
 rtl/uart_rx_sampler.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART receive sampler with centre sampling and one-entry holding buffer
//
// Purpose: synchronizes the serial rx line and detects start bits. Samples
// data and stop bits at their centres using the 16x baud tick, and delivers
// completed frames through a one-entry valid/ready holding buffer.
//
// Ports:
//   clk        single clock for all logic
//   rst_n      asynchronous assert, active-low reset
//   s_tick     one-clk strobe at OVERSAMPLE x baud rate
//   rx         asynchronous serial line, idle high
//   rx_data    received data word, valid while rx_valid is high
//   rx_valid   holding buffer full
//   rx_ready   consumer accepts rx_data when high together with rx_valid
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: frame completed while the buffer was full and not drained

module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nx;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        s_cnt, s_cnt_nx;
    logic [NW-1:0]        n, n_nx;
    logic [DATA_BITS-1:0] sh, sh_nx;
    logic                 frame_ok, frame_bad;

    // Two-flop synchronizer; resets to the idle (high) line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            s_cnt <= '0;
            n     <= '0;
            sh    <= '0;
        end else begin
            state <= state_nx;
            s_cnt <= s_cnt_nx;
            n     <= n_nx;
            sh    <= sh_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        s_cnt_nx  = s_cnt;
        n_nx      = n;
        sh_nx     = sh;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    s_cnt_nx = '0;
                    state_nx = S_START;
                end
            end
            S_START: begin
                // Half a bit time after the falling edge: re-check the line so
                // short glitches are rejected as false starts.
                if (s_tick) begin
                    if (s_cnt == HALF_CNT) begin
                        if (rx_s) begin
                            state_nx = S_IDLE;
                        end else begin
                            s_cnt_nx = '0;
                            n_nx     = '0;
                            state_nx = S_DATA;
                        end
                    end else begin
                        s_cnt_nx = s_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_cnt == LAST_CNT) begin
                        // LSB arrives first, so shift right from the top.
                        sh_nx    = {rx_s, sh[DATA_BITS-1:1]};
                        s_cnt_nx = '0;
                        if (n == LAST_BIT) begin
                            state_nx = S_STOP;
                        end else begin
                            n_nx = n + 1'b1;
                        end
                    end else begin
                        s_cnt_nx = s_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (s_cnt == LAST_CNT) begin
                        s_cnt_nx = '0;
                        if (rx_s) begin
                            frame_ok = 1'b1;
                            state_nx = S_IDLE;
                        end else begin
                            frame_bad = 1'b1;
                            state_nx  = S_BREAK;
                        end
                    end else begin
                        s_cnt_nx = s_cnt + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must not retrigger: wait for idle first.
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Holding buffer. A completed frame loads when empty or when the current
    // word is being drained in the same cycle; otherwise the new word is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (frame_ok) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= sh;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler
module tb_uart_rx_sampler;

    logic       clk;
    logic       rst_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int tick_no    = 0;
    int tick_div   = 0;
    int stop_tick  = -1;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int valid_cycles = 0;
    int ferr_cycles  = 0;
    int ovr_cycles   = 0;
    int valid_falls  = 0;
    logic prev_valid = 1'b0;

    int exp_ferr = 0;
    int exp_ovr  = 0;
    int vc0;
    int g;
    bit hit;
    logic [7:0] rb;
    logic       rs;

    uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tick   (s_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clk out of every four, driven just after the edge.
    always @(posedge clk) begin
        #1;
        s_tick = (tick_div == 0);
        if (tick_div == 0) tick_no++;
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    end

    // Observe outputs on the falling edge; valid&ready here is the handshake
    // that the next rising edge will perform.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
        if (rx_valid === 1'b1) valid_cycles++;
        if (frame_err === 1'b1) ferr_cycles++;
        if (overrun === 1'b1) ovr_cycles++;
        if (prev_valid === 1'b1 && rx_valid === 1'b0) valid_falls++;
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_accepted(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Sends one 8N1 frame, 64 clk per bit. The start edge is placed three
    // clocks after a tick so the first counted tick is unambiguous; the
    // stop-bit centre tick is then the 152nd tick from there.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while (s_tick !== 1'b1 && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        stop_tick = tick_no + 153;
        repeat (3) @(posedge clk);
        #2 rx = 1'b0;
        repeat (64) @(posedge clk);
        #2;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                repeat (20) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                check("rst_mid_rx_data", 32'(rx_data), 32'h0);
                check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
                check("rst_mid_frame_err", 32'(frame_err), 32'h0);
                check("rst_mid_overrun", 32'(overrun), 32'h0);
                repeat (10) @(posedge clk);
                #2 rst_n = 1'b1;
                repeat (34) @(posedge clk);
                #2;
            end else begin
                repeat (64) @(posedge clk);
                #2;
            end
        end
        rx = stop_bit;
        repeat (stop_bit ? 64 : 128) @(posedge clk);
        #2 rx = 1'b1;
        repeat (48) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        s_tick   = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;

        // 0xA5 with consumer always ready: single-cycle valid pulse.
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        check_accepted("a5");
        check("a5_valid_width", 32'(valid_cycles - vc0), 32'd1);
        check("a5_ferr", 32'(ferr_cycles), 32'(exp_ferr));
        check("a5_ovr", 32'(ovr_cycles), 32'(exp_ovr));

        // Glitch: low for 3 ticks only.
        vc0 = valid_cycles;
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #2 rx = 1'b1;
        repeat (200) @(posedge clk);
        #2;
        check("glitch_valid", 32'(valid_cycles - vc0), 32'd0);
        check("glitch_ferr", 32'(ferr_cycles), 32'(exp_ferr));

        // Bad stop bit with line held low past the stop, then a good frame.
        send_frame(8'h3C, 1'b0, -1);
        exp_ferr++;
        check_accepted("bad_stop");
        check("bad_stop_ferr", 32'(ferr_cycles), 32'(exp_ferr));
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        check_accepted("after_break");
        check("after_break_ferr", 32'(ferr_cycles), 32'(exp_ferr));

        // Overrun: consumer stalled for two frames.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        exp_ovr++;
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_pulse", 32'(ovr_cycles), 32'(exp_ovr));
        rx_ready = 1'b1;
        exp_q.push_back(8'h11);
        @(posedge clk);
        #2 rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_drain_valid", 32'(rx_valid), 32'h0);
        check_accepted("ovr_drain");

        // Drain and load on the same edge.
        send_frame(8'h11, 1'b1, -1);
        valid_falls = 0;
        hit = 1'b0;
        g = 0;
        stop_tick = -1;
        fork
            send_frame(8'h22, 1'b1, -1);
            begin
                while (!hit && g < 2000) begin
                    @(posedge clk); #2;
                    g++;
                    if (stop_tick >= 0 && s_tick === 1'b1 && tick_no == stop_tick) begin
                        rx_ready = 1'b1;
                        hit = 1'b1;
                        @(posedge clk);
                        #2 rx_ready = 1'b0;
                    end
                end
            end
        join
        check("same_edge_ready_hit", 32'(hit), 32'h1);
        exp_q.push_back(8'h11);
        check_accepted("same_edge_accept");
        check("same_edge_valid", 32'(rx_valid), 32'h1);
        check("same_edge_data", 32'(rx_data), 32'h22);
        check("same_edge_no_fall", 32'(valid_falls), 32'd0);
        check("same_edge_ovr", 32'(ovr_cycles), 32'(exp_ovr));

        // Reset during data bit 4 of 0xFF (buffer holds 0x22), then 0x5A.
        send_frame(8'hFF, 1'b1, 4);
        check("post_rst_valid", 32'(rx_valid), 32'h0);
        check("post_rst_ferr", 32'(ferr_cycles), 32'(exp_ferr));
        rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1);
        check_accepted("after_reset");

        // Random frames, about one in four with a bad stop bit.
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            if (rs) exp_q.push_back(rb);
            else exp_ferr++;
            send_frame(rb, rs, -1);
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #2;
        end
        check_accepted("random");
        check("random_ferr", 32'(ferr_cycles), 32'(exp_ferr));
        check("random_ovr", 32'(ovr_cycles), 32'(exp_ovr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
